mux_n_1_rr: RTL and testbench

- Parametrised N:1 data multiplexer with per-channel valid/ready handshake and a registered output stage.
- Select source is either an external select (manual mode) or an internal round-robin arbiter (RR mode), chosen at runtime.
- Sits between multiple producer channels and a single downstream consumer in the MBA datapath.
- Successor to the fixed 4:1 combinational mux trees.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_pick.sv | 34 +++
 rtl/mux_n_1_rr.sv | 122 ++++++++++++
 tb/tb_mux_n_1_rr.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 round-robin multiplexer.
package mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // A width of at least one bit keeps single-channel selects legal.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr_i, wrapping at NUM_CH.
module rr_pick
   import mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = clog2_min1(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [SEL_W-1:0]  ptr_i,
   output logic              gnt_vld_o,
   output logic [SEL_W-1:0]  gnt_idx_o
);

   localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

   logic [NUM_CH-1:0] req_rot;
   logic [SEL_W-1:0]  off;
   logic [SEL_W:0]    sum;

   // Rotating a doubled copy wraps at NUM_CH, even when NUM_CH is not a power of two.
   assign req_rot = NUM_CH'({req_i, req_i} >> ptr_i);

   always_comb begin
      off = '0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (req_rot[i]) off = SEL_W'(i);
      end
   end

   assign gnt_vld_o = |req_rot;
   assign sum       = {1'b0, ptr_i} + {1'b0, off};
   assign gnt_idx_o = (sum >= NUM_CH_W) ? SEL_W'(sum - NUM_CH_W) : sum[SEL_W-1:0];

endmodule

// File: rtl/mux_n_1_rr.sv
// N:1 valid/ready multiplexer with a registered output, selecting either manually or round-robin.
// Defining MUX_SEL_ERR_EN adds sel_err_o, which flags an out-of-range manual select.
module mux_n_1_rr
   import mux_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = clog2_min1(NUM_CH)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_CH*WIDTH-1:0] data_i,
   input  logic [NUM_CH-1:0]       valid_i,
   output logic [NUM_CH-1:0]       ready_o,
   input  logic                    mode_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    valid_o,
   output logic [SEL_W-1:0]        ch_o,
`ifdef MUX_SEL_ERR_EN
   output logic                    sel_err_o,
`endif
   input  logic                    ready_i
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH-1);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic             load_en;
   logic             man_vld;
   logic             rr_vld;
   logic [SEL_W-1:0] rr_idx;
   logic             gnt_vld;
   logic [SEL_W-1:0] gnt_idx;
   logic [WIDTH-1:0] gnt_data;

   assign load_en = !valid_q || ready_i;

   rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
      .req_i     (valid_i),
      .ptr_i     (ptr_q),
      .gnt_vld_o (rr_vld),
      .gnt_idx_o (rr_idx)
   );

   // Selects of NUM_CH and above match no channel, so they give no grant.
   always_comb begin
      man_vld = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel_i == SEL_W'(k) && valid_i[k]) man_vld = 1'b1;
      end
   end

   always_comb begin
      gnt_vld = (mode_i == MODE_RR) ? rr_vld : man_vld;
      gnt_idx = (mode_i == MODE_RR) ? rr_idx : sel_i;
   end

   always_comb begin
      ready_o  = '0;
      gnt_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (gnt_idx == SEL_W'(k)) begin
            gnt_data   = data_i[k*WIDTH +: WIDTH];
            ready_o[k] = load_en && gnt_vld;
         end
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      if (load_en) begin
         valid_d = gnt_vld;
         if (gnt_vld) begin
            data_d = gnt_data;
            ch_d   = gnt_idx;
            if (mode_i == MODE_RR) ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign ch_o    = ch_q;

`ifdef MUX_SEL_ERR_EN
   localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

   logic sel_err_q, sel_err_d;

   assign sel_err_d = (mode_i == MODE_MANUAL) && ({1'b0, sel_i} >= NUM_CH_W);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sel_err_q <= 1'b0;
      else         sel_err_q <= sel_err_d;
   end

   assign sel_err_o = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Scoreboard bench for mux_n_1_rr: a 4-channel instance and a 3-channel instance.
module tb_mux_n_1_rr;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] ch;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] d4 = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
   logic [3:0]  v4, r4o;
   logic        m4, vo4, ri4;
   logic [1:0]  s4, co4;
   logic [7:0]  do4;
   exp_t        q4[$];

   logic [23:0] d3 = {8'h33, 8'h22, 8'h11};
   logic [2:0]  v3, r3o;
   logic        m3, vo3, ri3;
   logic [1:0]  s3, co3;
   logic [7:0]  do3;
   exp_t        q3[$];
`ifdef MUX_SEL_ERR_EN
   logic        se4, se3;
`endif

   always #5 clk = ~clk;

   mux_n_1_rr #(.WIDTH(8), .NUM_CH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .data_i(d4), .valid_i(v4), .ready_o(r4o),
      .mode_i(m4), .sel_i(s4), .data_o(do4), .valid_o(vo4), .ch_o(co4),
`ifdef MUX_SEL_ERR_EN
      .sel_err_o(se4),
`endif
      .ready_i(ri4)
   );

   mux_n_1_rr #(.WIDTH(8), .NUM_CH(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .data_i(d3), .valid_i(v3), .ready_o(r3o),
      .mode_i(m3), .sel_i(s3), .data_o(do3), .valid_o(vo3), .ch_o(co3),
`ifdef MUX_SEL_ERR_EN
      .sel_err_o(se3),
`endif
      .ready_i(ri3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step4(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                        input logic [3:0] exp_rdy, input bit push, input logic [1:0] ch);
      @(posedge clk); #1;
      m4 = m; s4 = s; v4 = v; ri4 = r;
      #1;
      chk("ready4", r4o, exp_rdy);
      if (push) q4.push_back(exp_t'{d: d4[ch*8 +: 8], ch: ch});
   endtask

   task automatic step3(input logic m, input logic [1:0] s, input logic [2:0] v, input logic r,
                        input logic [2:0] exp_rdy, input bit push, input logic [1:0] ch);
      @(posedge clk); #1;
      m3 = m; s3 = s; v3 = v; ri3 = r;
      #1;
      chk("ready3", r3o, exp_rdy);
      if (push) q3.push_back(exp_t'{d: d3[ch*8 +: 8], ch: ch});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && vo4 && ri4) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL out4_unexpected actual ch=%0d data=%0h required none", co4, do4);
         end else begin
            e = q4.pop_front();
            chk("data4", do4, e.d);
            chk("ch4", co4, e.ch);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && vo3 && ri3) begin
         if (q3.size() == 0) begin
            checks++; errors++;
            $display("FAIL out3_unexpected actual ch=%0d data=%0h required none", co3, do3);
         end else begin
            e = q3.pop_front();
            chk("data3", do3, e.d);
            chk("ch3", co3, e.ch);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      m4 = 1'b0; s4 = 2'd0; v4 = 4'b0; ri4 = 1'b1;
      m3 = 1'b0; s3 = 2'd0; v3 = 3'b0; ri3 = 1'b1;
      #1;
      chk("rst_valid4", vo4, 0);
      chk("rst_data4", do4, 0);
      chk("rst_ch4", co4, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // manual select of channel 2
      step4(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1, 2'd2);
      // round-robin, all valid: 0,1,2,3,0,1,2,3
      for (int i = 0; i < 8; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (i % 4);
         step4(1'b1, 2'd0, 4'b1111, 1'b1, oh, 1, 2'(i % 4));
      end
      // channel 1 dropped: 0,2,3,0,2
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b0001, 1, 2'd0);
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b0100, 1, 2'd2);
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b1000, 1, 2'd3);
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b0001, 1, 2'd0);
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b0100, 1, 2'd2);
      // backpressure holds the channel-2 word
      for (int i = 0; i < 3; i++) begin
         step4(1'b1, 2'd0, 4'b1101, 1'b0, 4'b0000, 0, 2'd0);
         chk("hold_valid4", vo4, 1);
         chk("hold_data4", do4, 8'hA5);
         chk("hold_ch4", co4, 2);
      end
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b1000, 1, 2'd3);
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b0001, 1, 2'd0);
      step4(1'b1, 2'd0, 4'b1101, 1'b1, 4'b0100, 1, 2'd2);
      // manual excursion; the pointer stays at 3
      step4(1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1, 2'd1);
      step4(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1, 2'd0);
      step4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1, 2'd3);
      step4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1, 2'd0);
      // manual select of an invalid channel: no grant, output drains
      step4(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 0, 2'd0);
      step4(1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 0, 2'd0);
      chk("drain_valid4", vo4, 0);
      chk("drain_data4", do4, 8'h3C);
      chk("drain_ch4", co4, 0);
      // asynchronous reset while a word is held
      step4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1, 2'd1);
      step4(1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 0, 2'd0);
      chk("pre_rst_valid4", vo4, 1);
      chk("pre_rst_data4", do4, 8'h5A);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid4", vo4, 0);
      chk("async_rst_data4", do4, 0);
      chk("async_rst_ch4", co4, 0);
      q4.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      step4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1, 2'd0);
      step4(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 0, 2'd0);
      step4(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 0, 2'd0);

      // three-channel instance: wrap from pointer 2 to channel 0
      step3(1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1, 2'd0);
      step3(1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1, 2'd1);
      step3(1'b1, 2'd0, 3'b011, 1'b1, 3'b001, 1, 2'd0);
      step3(1'b1, 2'd0, 3'b011, 1'b1, 3'b010, 1, 2'd1);
      step3(1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 0, 2'd0);
      step3(1'b0, 2'd3, 3'b000, 1'b1, 3'b000, 0, 2'd0);
      chk("sel3_valid3", vo3, 0);
      chk("sel3_data3", do3, 8'h22);
      chk("sel3_ch3", co3, 1);
`ifdef MUX_SEL_ERR_EN
      chk("sel_err3_set", se3, 1);
`endif
      step3(1'b0, 2'd2, 3'b111, 1'b1, 3'b100, 1, 2'd2);
      step3(1'b0, 2'd2, 3'b000, 1'b1, 3'b000, 0, 2'd0);
`ifdef MUX_SEL_ERR_EN
      chk("sel_err3_clr", se3, 0);
`endif
      step3(1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 0, 2'd0);
      step3(1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 0, 2'd0);

      chk("q4_empty", q4.size(), 0);
      chk("q3_empty", q3.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
